bfp16_accumulator: RTL and testbench

BFP16_ACCUMULATOR -- requirements
Module: bfp16_accumulator

---
 rtl/bfp16_pkg.sv | 28 ++
 rtl/bfp16_add_comb.sv | 72 +++++++
 rtl/bfp16_accumulator.sv | 70 +++++++
 tb/tb_bfp16_accumulator.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bfp16_pkg.sv
// Shared bfp16 field layout, constants and helpers.
// Imported by the accumulator and its adder datapath.
package bfp16_pkg;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 7;
    localparam int EXP_BIAS = 127;

    localparam logic [EXP_W-1:0] EXP_MAX    = 8'hFF;
    localparam logic [15:0]      BFP16_ZERO = 16'h0000;
    localparam logic [15:0]      BFP16_QNAN = 16'h7FC0;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } bfp16_t;

    // Leading-zero count of an 8-bit significand (v != 0 assumed).
    function automatic logic [2:0] lzc8(input logic [7:0] v);
        lzc8 = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) lzc8 = 3'(7 - i);
        end
    endfunction

endpackage

// File: rtl/bfp16_add_comb.sv
// Combinational bfp16 adder: truncating alignment, flush-to-zero,
// saturation to infinity and infinity/NaN propagation.
module bfp16_add_comb
    import bfp16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s
);

    bfp16_t     ua, ub;
    logic [7:0] ma, mb;
    logic       swap;
    logic       sl, ss;
    logic [7:0] el, es, ml, ms;
    logic [7:0] diff, ms_sh;
    logic [8:0] sum9;
    logic [7:0] dif8;
    logic [2:0] lz;
    logic [7:0] mant;
    logic [8:0] re;
    logic       zero;

    assign ua = bfp16_t'(a);
    assign ub = bfp16_t'(b);

    // Align, add/subtract magnitudes, normalize and classify the result.
    always_comb begin
        ma    = (ua.exp == 8'd0) ? 8'd0 : {1'b1, ua.frac};
        mb    = (ub.exp == 8'd0) ? 8'd0 : {1'b1, ub.frac};
        swap  = {ub.exp, mb} > {ua.exp, ma};
        sl    = swap ? ub.sign[0] : ua.sign[0];
        ss    = swap ? ua.sign[0] : ub.sign[0];
        el    = swap ? ub.exp : ua.exp;
        es    = swap ? ua.exp : ub.exp;
        ml    = swap ? mb : ma;
        ms    = swap ? ma : mb;
        diff  = el - es;
        ms_sh = (diff >= 8'd8) ? 8'd0 : (ms >> diff[2:0]);
        sum9  = {1'b0, ml} + {1'b0, ms_sh};
        dif8  = ml - ms_sh;
        lz    = lzc8(dif8);
        mant  = 8'd0;
        re    = 9'd0;
        zero  = 1'b0;
        if (sl == ss) begin
            mant = sum9[8] ? sum9[8:1] : sum9[7:0];
            re   = {1'b0, el} + {8'd0, sum9[8]};
            zero = (sum9 == 9'd0);
        end else begin
            mant = dif8 << lz;
            re   = {1'b0, el} - {6'd0, lz};
            zero = (dif8 == 8'd0) || (el <= {5'd0, lz});
        end

        if (ua.exp == EXP_MAX && ub.exp == EXP_MAX) begin
            s = (ua.sign != ub.sign) ? BFP16_QNAN
                                     : {ua.sign, EXP_MAX, 7'd0};
        end else if (ua.exp == EXP_MAX) begin
            s = {ua.sign, EXP_MAX, 7'd0};
        end else if (ub.exp == EXP_MAX) begin
            s = {ub.sign, EXP_MAX, 7'd0};
        end else if (zero) begin
            s = BFP16_ZERO;
        end else if (re > 9'd254) begin
            s = {sl, EXP_MAX, 7'd0};
        end else begin
            s = {sl, re[7:0], mant[6:0]};
        end
    end

endmodule

// File: rtl/bfp16_accumulator.sv
// Streams bfp16 partial sums into a running total and hands the
// final dot-product sum downstream with its beat count.
module bfp16_accumulator
    import bfp16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]       state;
    logic [15:0]      acc;
    logic [15:0]      sum;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    bfp16_add_comb u_add (
        .a (acc),
        .b (in_data),
        .s (sum)
    );

    assign in_ready  = !rst && (state == ST_ACCUM);
    assign out_valid = !rst && (state == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign out_data  = acc;
    assign out_count = cnt;

    // Accumulate accepted beats, park the result until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACCUM;
            acc   <= BFP16_ZERO;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        acc <= sum;
                        cnt <= cnt_inc;
                        if (in_last) state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_ACCUM;
                        acc   <= BFP16_ZERO;
                        cnt   <= '0;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_bfp16_accumulator.sv
// Directed bench for bfp16_accumulator with hand-computed sums.
// Each check is an immediate assertion counted in the summary.
module tb_bfp16_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_count;

    int n_checks = 0;
    int n_fail   = 0;

    bfp16_accumulator #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic result(input string tag, input logic [15:0] d,
                          input logic [7:0] c);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_count"}, 32'(out_count), 32'(c));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'h0000);
        chk("rst_out_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        beat(16'h3F80, 1'b0);
        beat(16'h4000, 1'b1);
        result("one_plus_two", 16'h4040, 8'd2);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        take();
        chk("take_valid", 32'(out_valid), 32'd0);
        chk("take_ready", 32'(in_ready),  32'd1);
        chk("take_acc",   32'(out_data),  32'h0000);
        chk("take_cnt",   32'(out_count), 32'd0);

        beat(16'h3F80, 1'b0);
        beat(16'hBF80, 1'b1);
        result("cancel", 16'h0000, 8'd2);
        take();

        beat(16'h3F00, 1'b1);
        result("single", 16'h3F00, 8'd1);
        take();

        beat(16'h7F7F, 1'b0);
        beat(16'h7F7F, 1'b1);
        result("overflow", 16'h7F80, 8'd2);
        take();

        beat(16'h7F80, 1'b0);
        beat(16'hFF80, 1'b1);
        result("inf_minus_inf", 16'h7FC0, 8'd2);
        take();

        beat(16'h4000, 1'b0);
        beat(16'hBF80, 1'b1);
        result("two_minus_one", 16'h3F80, 8'd2);
        take();

        beat(16'h0080, 1'b0);
        beat(16'h80C0, 1'b1);
        result("underflow", 16'h0000, 8'd2);
        take();

        beat(16'hFF80, 1'b0);
        beat(16'h3F80, 1'b1);
        result("neg_inf_prop", 16'hFF80, 8'd2);
        take();

        beat(16'h3F80, 1'b0);
        beat(16'h4000, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h4000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ready", 32'(in_ready),  32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data",  32'(out_data),  32'h4040);
            chk("stall_count", 32'(out_count), 32'd2);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take();
        beat(16'h4000, 1'b1);
        result("after_hold", 16'h4000, 8'd1);
        take();

        beat(16'h3F80, 1'b0);
        beat(16'h3F80, 1'b0);
        beat(16'h3F80, 1'b0);
        rst = 1'b1;
        tick();
        chk("midrst_ready", 32'(in_ready),  32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", 32'(in_ready), 32'd1);
        beat(16'h4000, 1'b0);
        beat(16'h4000, 1'b1);
        result("after_rst", 16'h4080, 8'd2);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("holdrst_valid", 32'(out_valid), 32'd0);
        chk("holdrst_count", 32'(out_count), 32'd0);
        chk("holdrst_data",  32'(out_data),  32'h0000);
        chk("holdrst_ready", 32'(in_ready),  32'd1);

        beat(16'h3F80, 1'b0);
        tick();
        tick();
        beat(16'h3F80, 1'b1);
        result("gapped", 16'h4000, 8'd2);
        take();

        beat(16'h4B00, 1'b0);
        tick();
        tick();
        beat(16'h3F80, 1'b1);
        result("truncate", 16'h4B00, 8'd2);
        take();

        for (int i = 0; i < 260; i++) beat(16'h0000, 1'b0);
        beat(16'h3F80, 1'b1);
        result("saturate", 16'h3F80, 8'd255);
        take();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
